// File: rtl/seq11011_pkg.sv
// Shared definitions for the 11011 serial pattern transmitter.
//   - state encoding for the transmitter FSM
//   - default frame pattern and its width
//   - total_valid(): number of out_valid cycles for an N-frame transfer
package seq11011_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int             DEF_PAT_W   = 5;
    localparam logic [4:0]     DEF_PATTERN = 5'b11011;

    // N frames of pat_w bits with gap zero bits between frames, none after the last.
    function automatic int total_valid(input int n, input int pat_w, input int gap);
        if (n <= 0) return 0;
        return n * pat_w + (n - 1) * gap;
    endfunction

endpackage

// File: rtl/seq11011_gen_if.sv
// Control/serial bus of the 11011 transmitter.
//   start, n_frames : request side (driven by the requester, master)
//   err_inj         : last-frame corruption request, only with SEQ11011_GEN_ERR_INJ_EN
//   out, out_valid  : serial bit stream with qualifier
//   busy, done      : transfer status
interface seq11011_gen_if #(parameter int CNT_W = 8);
    logic             start;
    logic [CNT_W-1:0] n_frames;
`ifdef SEQ11011_GEN_ERR_INJ_EN
    logic             err_inj;
`endif
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
`ifdef SEQ11011_GEN_ERR_INJ_EN
        output err_inj,
`endif
        output start, n_frames,
        input  out, out_valid, busy, done
    );

    modport slave (
`ifdef SEQ11011_GEN_ERR_INJ_EN
        input  err_inj,
`endif
        input  start, n_frames,
        output out, out_valid, busy, done
    );
endinterface

// File: rtl/seq_piso_shift.sv
// Loadable parallel-in/serial-out shift register, MSB first.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture din (has priority over shift)
//   shift    : shift left by one, zero fill
//   din      : parallel load value
//   dout     : current MSB
module seq_piso_shift #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);
    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst)        q <= '0;
        else if (load)  q <= din;
        else if (shift) q <= {q[W-2:0], 1'b0};
    end

    assign dout = q[W-1];
endmodule

// File: rtl/seq11011_gen.sv
// 11011 serial frame transmitter.
// On an accepted start, sends n_frames copies of PATTERN MSB first on out with
// out_valid, separated by GAP zero bits, then pulses done for one cycle.
// Ports: clk, rst (sync, active-high), bus (seq11011_gen_if.slave).
// Optional: SEQ11011_GEN_ERR_INJ_EN adds bus.err_inj; when captured high the
// LSB of the last frame is inverted.
module seq11011_gen
    import seq11011_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               GAP     = 2,
    parameter int               CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq11011_gen_if.slave  bus
);
    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    state_t           state_q, state_n;
    logic [BW-1:0]    bit_q, bit_n;
    logic [CNT_W-1:0] frame_q, frame_n;   // frames remaining, including the current one
    logic [GW-1:0]    gap_q, gap_n;
    logic             out_q, out_n, vld_q, vld_n, busy_q, busy_n, done_q, done_n;

    logic             sh_load, sh_shift, sh_dout;
    logic [PAT_W-1:0] sh_din, fb;
    logic             inj_now;

`ifdef SEQ11011_GEN_ERR_INJ_EN
    logic err_q, err_n;
`else
    localparam logic err_q = 1'b0;
`endif

    function automatic logic [PAT_W-1:0] frame_bits(input logic inv);
        return PATTERN ^ {{(PAT_W-1){1'b0}}, inv};
    endfunction

    // The out register carries the current bit; the shifter holds the bits
    // still to come, so it is loaded with the frame already shifted by one.
    seq_piso_shift #(.W(PAT_W)) u_sh (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .dout  (sh_dout)
    );

    always_comb begin
        state_n  = state_q;
        bit_n    = bit_q;
        frame_n  = frame_q;
        gap_n    = gap_q;
        out_n    = 1'b0;
        vld_n    = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = '0;
        fb       = '0;
`ifdef SEQ11011_GEN_ERR_INJ_EN
        err_n    = err_q;
        inj_now  = bus.err_inj;
`else
        inj_now  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    frame_n = bus.n_frames;
`ifdef SEQ11011_GEN_ERR_INJ_EN
                    err_n   = bus.err_inj;
`endif
                    busy_n  = 1'b1;
                    if (bus.n_frames == '0) begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_SEND;
                        fb      = frame_bits(inj_now && (bus.n_frames == CNT_W'(1)));
                        sh_load = 1'b1;
                        sh_din  = fb << 1;
                        out_n   = fb[PAT_W-1];
                        vld_n   = 1'b1;
                        bit_n   = BW'(PAT_W - 1);
                    end
                end
            end
            ST_SEND: begin
                busy_n = 1'b1;
                if (bit_q != '0) begin
                    sh_shift = 1'b1;
                    out_n    = sh_dout;
                    vld_n    = 1'b1;
                    bit_n    = bit_q - 1'b1;
                end else begin
                    frame_n = frame_q - 1'b1;
                    if (frame_q > CNT_W'(1)) begin
                        vld_n = 1'b1;
                        if (GAP > 0) begin
                            state_n = ST_GAP;
                            gap_n   = GW'(GAP > 0 ? GAP - 1 : 0);
                        end else begin
                            // back-to-back: next frame is the last when two remain now
                            fb      = frame_bits(err_q && (frame_q == CNT_W'(2)));
                            sh_load = 1'b1;
                            sh_din  = fb << 1;
                            out_n   = fb[PAT_W-1];
                            bit_n   = BW'(PAT_W - 1);
                        end
                    end else begin
                        state_n = ST_DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                busy_n = 1'b1;
                vld_n  = 1'b1;
                if (gap_q == '0) begin
                    state_n = ST_SEND;
                    fb      = frame_bits(err_q && (frame_q == CNT_W'(1)));
                    sh_load = 1'b1;
                    sh_din  = fb << 1;
                    out_n   = fb[PAT_W-1];
                    bit_n   = BW'(PAT_W - 1);
                end else begin
                    gap_n = gap_q - 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            frame_q <= '0;
            gap_q   <= '0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            bit_q   <= bit_n;
            frame_q <= frame_n;
            gap_q   <= gap_n;
            out_q   <= out_n;
            vld_q   <= vld_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

`ifdef SEQ11011_GEN_ERR_INJ_EN
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_n;
    end
`endif

    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq11011_gen.sv
module tb_seq11011_gen;
    import seq11011_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    seq11011_gen_if #(.CNT_W(8)) bif ();

    seq11011_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input int n);
        bif.n_frames = 8'(n);
        bif.start    = 1'b1;
        tick();
        bif.start    = 1'b0;
    endtask

    // Starting in cycle 1 of a transfer, gather valid bits until done or timeout.
    // A bench-side non-overlapping 11011 detector runs on the valid bits.
    task automatic collect(input int max, input int pulse_a, input int pulse_b,
                           output int nvalid, output int ndet, output int done_cyc,
                           output logic [63:0] bits);
        logic [4:0] det;
        int         bad_zero;
        det      = '0;
        nvalid   = 0;
        ndet     = 0;
        done_cyc = -1;
        bits     = '0;
        bad_zero = 0;
        for (int c = 1; c <= max; c++) begin
            if (bif.out_valid) begin
                bits = {bits[62:0], bif.out};
                nvalid++;
                det = {det[3:0], bif.out};
                if (det == 5'b11011) begin
                    ndet++;
                    det = '0;
                end
            end else if (bif.out !== 1'b0) begin
                bad_zero++;
            end
            if (bif.done === 1'b1) begin
                done_cyc = c;
                break;
            end
            bif.start = (c == pulse_a || c == pulse_b);
            tick();
        end
        bif.start = 1'b0;
        check("out_zero_when_invalid", 64'(bad_zero), 64'd0);
        if (done_cyc < 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    int          nv, nd, dc;
    logic [63:0] bits;
    logic [4:0]  exp1;

    initial begin
        bif.start    = 1'b0;
        bif.n_frames = '0;
`ifdef SEQ11011_GEN_ERR_INJ_EN
        bif.err_inj  = 1'b0;
`endif
        // reset, with start held high to confirm rst wins
        bif.start = 1'b1;
        bif.n_frames = 8'd1;
        tick(); tick(); tick();
        check("rst_out",   64'(bif.out),       64'd0);
        check("rst_valid", 64'(bif.out_valid), 64'd0);
        check("rst_busy",  64'(bif.busy),      64'd0);
        check("rst_done",  64'(bif.done),      64'd0);
        bif.start = 1'b0;
        rst = 1'b0;
        tick();

        // single frame: cycles 1-5 carry 1,1,0,1,1; done in cycle 6
        exp1 = 5'b11011;
        start_xfer(1);
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("n1_valid_c%0d", c), 64'(bif.out_valid), 64'd1);
            check($sformatf("n1_out_c%0d", c),   64'(bif.out),       64'(exp1[5-c]));
            check($sformatf("n1_busy_c%0d", c),  64'(bif.busy),      64'd1);
            check($sformatf("n1_done_c%0d", c),  64'(bif.done),      64'd0);
            tick();
        end
        check("n1_done_c6",  64'(bif.done),      64'd1);
        check("n1_busy_c6",  64'(bif.busy),      64'd1);
        check("n1_valid_c6", 64'(bif.out_valid), 64'd0);
        tick();
        check("n1_done_c7", 64'(bif.done), 64'd0);
        check("n1_busy_c7", 64'(bif.busy), 64'd0);

        // three frames with GAP=2
        start_xfer(3);
        collect(60, 0, 0, nv, nd, dc, bits);
        check("n3_nvalid",   64'(nv), 64'd19);
        check("n3_pkg_fn",   64'(nv), 64'(total_valid(3, 5, 2)));
        check("n3_bits",     bits & 64'h7FFFF, 64'b1101100110110011011);
        check("n3_det",      64'(nd), 64'd3);
        check("n3_done_cyc", 64'(dc), 64'd20);
        tick();

        // repeated start pulses mid-transfer are ignored
        start_xfer(3);
        collect(60, 4, 12, nv, nd, dc, bits);
        check("n3p_nvalid",   64'(nv), 64'd19);
        check("n3p_done_cyc", 64'(dc), 64'd20);
        tick();
        check("n3p_busy_after", 64'(bif.busy), 64'd0);
        // start in the cycle after done is accepted
        start_xfer(1);
        check("after_done_valid", 64'(bif.out_valid), 64'd1);
        check("after_done_busy",  64'(bif.busy),      64'd1);
        collect(20, 0, 0, nv, nd, dc, bits);
        check("after_done_nvalid", 64'(nv), 64'd5);
        check("after_done_bits",   bits & 64'h1F, 64'b11011);
        tick();

        // zero frames: done immediately, no valid bits
        start_xfer(0);
        check("n0_done",  64'(bif.done),      64'd1);
        check("n0_busy",  64'(bif.busy),      64'd1);
        check("n0_valid", 64'(bif.out_valid), 64'd0);
        tick();
        check("n0_done2", 64'(bif.done),      64'd0);
        check("n0_busy2", 64'(bif.busy),      64'd0);
        check("n0_valid2", 64'(bif.out_valid), 64'd0);

        // abort during the third bit of frame 2 (cycle 10)
        start_xfer(2);
        for (int c = 1; c < 10; c++) tick();
        check("abort_pre_valid", 64'(bif.out_valid), 64'd1);
        check("abort_pre_out",   64'(bif.out),       64'd0);
        check("abort_pre_busy",  64'(bif.busy),      64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out",   64'(bif.out),       64'd0);
        check("abort_valid", 64'(bif.out_valid), 64'd0);
        check("abort_busy",  64'(bif.busy),      64'd0);
        check("abort_done",  64'(bif.done),      64'd0);
        begin
            int dseen;
            dseen = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (bif.done === 1'b1 || bif.out_valid === 1'b1) dseen++;
            end
            check("abort_quiet", 64'(dseen), 64'd0);
        end
        start_xfer(1);
        collect(20, 0, 0, nv, nd, dc, bits);
        check("post_abort_nvalid", 64'(nv), 64'd5);
        check("post_abort_bits",   bits & 64'h1F, 64'b11011);
        check("post_abort_done",   64'(dc), 64'd6);
        tick();

`ifdef SEQ11011_GEN_ERR_INJ_EN
        bif.err_inj = 1'b1;
        start_xfer(3);
        bif.err_inj = 1'b0;
        collect(60, 0, 0, nv, nd, dc, bits);
        check("inj_bits", bits & 64'h7FFFF, 64'b1101100110110011010);
        check("inj_det",  64'(nd), 64'd2);
        tick();
        bif.err_inj = 1'b0;
        start_xfer(3);
        collect(60, 0, 0, nv, nd, dc, bits);
        check("noinj_bits", bits & 64'h7FFFF, 64'b1101100110110011011);
        check("noinj_det",  64'(nd), 64'd3);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
